// File: rtl/trainer_session_ctrl.sv
// trainer_session_ctrl: session controller for the cycle trainer.
// Debounces the start/stop button, fetches the rider profile level over a
// req/ack handshake, then round-robin scans NUM_CH sensor channels and
// publishes one OUT_W-bit reading per channel.
// Build option: define TRAINER_SAMPLE_AVG_EN to store the two-sample average
// (previous + new) >> 1 per slot instead of the raw truncated sample.
//
// state | meaning
// ------+------------------------------------------------------------
//   0   | IDLE   : quiet, waiting for a button press
//   1   | DB_REQ : requesting the rider profile, timeout running
//   2   | SCAN   : requesting sensor samples, channel by channel
//   3   | STOP   : one quiet cycle after an abort, then IDLE
//   4   | ERROR  : handshake timed out, press returns to IDLE
module trainer_session_ctrl #(
  parameter int NUM_CH  = 4,
  parameter int ADC_W   = 12,
  parameter int OUT_W   = 8,
  parameter int TIMEOUT = 1000,
  parameter int DEB_CYC = 16
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic                       button,
  input  logic                       db_ack,
  input  logic [OUT_W-1:0]           db_data,
  input  logic                       adc_valid,
  input  logic [ADC_W-1:0]           adc_data,
  output logic                       db_req,
  output logic                       sens_req,
  output logic [$clog2(NUM_CH)-1:0]  ch_sel,
  output logic [NUM_CH*OUT_W-1:0]    readings,
  output logic [OUT_W-1:0]           target,
  output logic                       sweep_done,
  output logic                       running,
  output logic                       error,
  output logic [2:0]                 state
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam int DW   = $clog2(DEB_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DB_REQ = 3'd1,
    S_SCAN   = 3'd2,
    S_STOP   = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t            state_q, state_nxt;
  logic              sync1, sync2, stable, stable_d, press;
  logic [DW-1:0]     deb_cnt;
  logic [TW-1:0]     tmo;
  logic              tmo_hit;
  logic [CH_W-1:0]   ch;
  logic              sample, last_ch, enter_scan;
  logic [OUT_W-1:0]  trunc, slot_val;
  logic              unused_bits;

  // Two-flop synchroniser for the asynchronous button
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
    end
  end

  // Debounce: stable level follows sync2 after DEB_CYC consecutive differing samples
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      deb_cnt  <= '0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
    end else begin
      stable_d <= stable;
      if (sync2 == stable) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DW'(DEB_CYC - 1)) begin
        stable  <= sync2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign press      = stable & ~stable_d;
  assign tmo_hit    = (tmo == TW'(TIMEOUT - 1));
  assign sample     = (state_q == S_SCAN) && adc_valid;
  assign last_ch    = (ch == CH_W'(NUM_CH - 1));
  assign enter_scan = (state_q == S_DB_REQ) && (state_nxt == S_SCAN);
  assign trunc      = adc_data[ADC_W-1 -: OUT_W];

  // FSM state register
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_nxt;
  end

  // FSM next-state logic; a press (abort) wins over ack and timeout
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE:   if (press) state_nxt = S_DB_REQ;
      S_DB_REQ: begin
        if (press)        state_nxt = S_STOP;
        else if (db_ack)  state_nxt = S_SCAN;
        else if (tmo_hit) state_nxt = S_ERROR;
      end
      S_SCAN: begin
        if (press)                     state_nxt = S_STOP;
        else if (!adc_valid && tmo_hit) state_nxt = S_ERROR;
      end
      S_STOP:   state_nxt = S_IDLE;
      S_ERROR:  if (press) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs, decoded from the current state
  always_comb begin
    db_req   = (state_q == S_DB_REQ);
    sens_req = (state_q == S_SCAN);
    running  = (state_q == S_DB_REQ) || (state_q == S_SCAN);
    error    = (state_q == S_ERROR);
    ch_sel   = (state_q == S_SCAN) ? ch : '0;
    state    = state_q;
  end

  // Saturating handshake timeout, restarted on state change and on each sample
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      tmo <= '0;
    end else if ((state_nxt != state_q) || sample) begin
      tmo <= '0;
    end else if (running && (tmo != TW'(TIMEOUT))) begin
      tmo <= tmo + 1'b1;
    end
  end

  // Channel pointer and end-of-sweep pulse
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      ch         <= '0;
      sweep_done <= 1'b0;
    end else begin
      sweep_done <= sample && last_ch;
      if (enter_scan)   ch <= '0;
      else if (sample)  ch <= last_ch ? '0 : ch + 1'b1;
    end
  end

  // Profile level capture on the database ack
  always_ff @(posedge clock or negedge rst) begin
    if (!rst)            target <= '0;
    else if (enter_scan) target <= db_data;
  end

`ifdef TRAINER_SAMPLE_AVG_EN
  logic [NUM_CH-1:0] slot_vld;
  logic [OUT_W:0]    avg_sum;

  assign avg_sum  = {1'b0, readings[ch*OUT_W +: OUT_W]} + {1'b0, trunc};
  assign slot_val = slot_vld[ch] ? avg_sum[OUT_W:1] : trunc;
  assign unused_bits = ^adc_data ^ avg_sum[0];

  // First sample of a slot after reset is stored raw, later ones averaged
  always_ff @(posedge clock or negedge rst) begin
    if (!rst)        slot_vld <= '0;
    else if (sample) slot_vld[ch] <= 1'b1;
  end
`else
  assign slot_val    = trunc;
  assign unused_bits = ^adc_data;
`endif

  // Reading slots, written for the channel being scanned
  always_ff @(posedge clock or negedge rst) begin
    if (!rst)        readings <= '0;
    else if (sample) readings[ch*OUT_W +: OUT_W] <= slot_val;
  end

endmodule

// File: tb/tb_trainer_session_ctrl.sv
// Directed bench for trainer_session_ctrl (default build, NUM_CH=4).
module tb_trainer_session_ctrl;

  logic        clock = 1'b0;
  logic        rst = 1'b0;
  logic        button = 1'b0;
  logic        db_ack = 1'b0;
  logic [7:0]  db_data = '0;
  logic        adc_valid = 1'b0;
  logic [11:0] adc_data = '0;
  logic        db_req, sens_req, sweep_done, running, error;
  logic [1:0]  ch_sel;
  logic [31:0] readings;
  logic [7:0]  target;
  logic [2:0]  state;

  int total = 0;
  int bad = 0;

  trainer_session_ctrl dut (
    .clock(clock), .rst(rst), .button(button), .db_ack(db_ack),
    .db_data(db_data), .adc_valid(adc_valid), .adc_data(adc_data),
    .db_req(db_req), .sens_req(sens_req), .ch_sel(ch_sel),
    .readings(readings), .target(target), .sweep_done(sweep_done),
    .running(running), .error(error), .state(state)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic test_reset;
    tick(3);
    total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0h want=0", state); end
    total++; if ({db_req, sens_req, running, error, sweep_done} !== 5'b0) begin bad++;
      $display("FAIL reset_flags got=%b want=00000", {db_req, sens_req, running, error, sweep_done}); end
    total++; if ({readings, target, ch_sel} !== 42'h0) begin bad++;
      $display("FAIL reset_data got=%h/%h/%h want=0", readings, target, ch_sel); end
    rst = 1'b1;
    tick(2);
  endtask

  task automatic test_glitch;
    int seen = 0;
    button = 1'b1;
    for (int i = 0; i < 10; i++) begin tick(1); if (db_req) seen++; end
    button = 1'b0;
    for (int i = 0; i < 25; i++) begin tick(1); if (db_req) seen++; end
    total++; if (seen != 0) begin bad++; $display("FAIL glitch_dbreq got=%0d cycles want=0", seen); end
    total++; if (state !== 3'd0) begin bad++; $display("FAIL glitch_state got=%0h want=0", state); end
  endtask

  task automatic test_press_latency;
    button = 1'b1;
    tick(18);
    total++; if (db_req !== 1'b0) begin bad++; $display("FAIL press_early got=%b want=0", db_req); end
    tick(1);
    total++; if (db_req !== 1'b1) begin bad++; $display("FAIL press_dbreq got=%b want=1", db_req); end
    total++; if (state !== 3'd1 || running !== 1'b1) begin bad++;
      $display("FAIL press_state got=%0h/%b want=1/1", state, running); end
    tick(11);
    button = 1'b0;
    tick(25);
    total++; if (state !== 3'd1) begin bad++; $display("FAIL dbreq_hold got=%0h want=1", state); end
  endtask

  task automatic test_sweep;
    logic [11:0] vals [4];
    logic [31:0] exp_rd;
    vals[0] = 12'h123; vals[1] = 12'h456; vals[2] = 12'h789; vals[3] = 12'hFFF;
    exp_rd = readings;
    db_data = 8'h5A; db_ack = 1'b1;
    tick(1);
    db_ack = 1'b0;
    total++; if (state !== 3'd2 || db_req !== 1'b0 || sens_req !== 1'b1) begin bad++;
      $display("FAIL ack_state got=%0h/%b/%b want=2/0/1", state, db_req, sens_req); end
    total++; if (target !== 8'h5A || ch_sel !== 2'd0) begin bad++;
      $display("FAIL ack_target got=%h/%0d want=5a/0", target, ch_sel); end
    for (int k = 0; k < 4; k++) begin
      adc_data = vals[k]; adc_valid = 1'b1;
      tick(1);
      adc_valid = 1'b0;
      exp_rd[k*8 +: 8] = vals[k][11:4];
      total++; if (readings !== exp_rd) begin bad++;
        $display("FAIL sweep_slot%0d got=%h want=%h", k, readings, exp_rd); end
      total++; if (sweep_done !== (k == 3)) begin bad++;
        $display("FAIL sweep_done%0d got=%b want=%b", k, sweep_done, (k == 3)); end
      total++; if (ch_sel !== 2'((k + 1) % 4)) begin bad++;
        $display("FAIL sweep_ch%0d got=%0d want=%0d", k, ch_sel, (k + 1) % 4); end
    end
    total++; if (readings !== 32'hFF784512) begin bad++; $display("FAIL sweep_final got=%h want=ff784512", readings); end
    tick(1);
    total++; if (sweep_done !== 1'b0 || state !== 3'd2) begin bad++;
      $display("FAIL sweep_after got=%b/%0h want=0/2", sweep_done, state); end
  endtask

  task automatic test_stop_with_sample;
    adc_data = 12'hABC; adc_valid = 1'b1;
    tick(1);
    adc_valid = 1'b0;
    total++; if (ch_sel !== 2'd1 || readings !== 32'hFF7845AB) begin bad++;
      $display("FAIL pre_stop got=%0d/%h want=1/ff7845ab", ch_sel, readings); end
    button = 1'b1;
    tick(18);
    adc_data = 12'h3C0; adc_valid = 1'b1;
    tick(1);
    adc_valid = 1'b0;
    total++; if (state !== 3'd3 || sens_req !== 1'b0) begin bad++;
      $display("FAIL stop_state got=%0h/%b want=3/0", state, sens_req); end
    total++; if (readings !== 32'hFF783CAB) begin bad++; $display("FAIL stop_slot1 got=%h want=ff783cab", readings); end
    tick(1);
    total++; if (state !== 3'd0) begin bad++; $display("FAIL stop_idle got=%0h want=0", state); end
    button = 1'b0;
    tick(25);
    total++; if (readings !== 32'hFF783CAB || target !== 8'h5A) begin bad++;
      $display("FAIL idle_hold got=%h/%h want=ff783cab/5a", readings, target); end
  endtask

  task automatic test_ignored_handshakes;
    db_data = 8'h11; db_ack = 1'b1; adc_data = 12'hEEE; adc_valid = 1'b1;
    tick(1);
    db_ack = 1'b0; adc_valid = 1'b0;
    tick(1);
    total++; if (target !== 8'h5A || readings !== 32'hFF783CAB || state !== 3'd0) begin bad++;
      $display("FAIL idle_ignore got=%h/%h/%0h want=5a/ff783cab/0", target, readings, state); end
  endtask

  task automatic test_timeout;
    button = 1'b1;
    tick(19);
    button = 1'b0;
    total++; if (state !== 3'd1) begin bad++; $display("FAIL tmo_start got=%0h want=1", state); end
    tick(999);
    total++; if (state !== 3'd1) begin bad++; $display("FAIL tmo_early got=%0h want=1", state); end
    tick(1);
    total++; if (state !== 3'd4 || error !== 1'b1 || db_req !== 1'b0 || running !== 1'b0) begin bad++;
      $display("FAIL tmo_error got=%0h/%b/%b/%b want=4/1/0/0", state, error, db_req, running); end
    tick(25);
    button = 1'b1;
    tick(18);
    total++; if (state !== 3'd4) begin bad++; $display("FAIL err_hold got=%0h want=4", state); end
    tick(1);
    total++; if (state !== 3'd0 || error !== 1'b0) begin bad++;
      $display("FAIL err_clear got=%0h/%b want=0/0", state, error); end
    button = 1'b0;
    tick(25);
    total++; if (state !== 3'd0) begin bad++; $display("FAIL err_idle got=%0h want=0", state); end
  endtask

  task automatic test_reset_midscan;
    button = 1'b1;
    tick(19);
    button = 1'b0;
    db_data = 8'h33; db_ack = 1'b1;
    tick(1);
    db_ack = 1'b0;
    total++; if (state !== 3'd2 || ch_sel !== 2'd0 || target !== 8'h33) begin bad++;
      $display("FAIL restart_ch0 got=%0h/%0d/%h want=2/0/33", state, ch_sel, target); end
    adc_data = 12'h9F0; adc_valid = 1'b1;
    tick(1);
    adc_valid = 1'b0;
    total++; if (readings !== 32'hFF783C9F || ch_sel !== 2'd1) begin bad++;
      $display("FAIL restart_slot0 got=%h/%0d want=ff783c9f/1", readings, ch_sel); end
    #2 rst = 1'b0;
    #1;
    total++; if ({state, db_req, sens_req, running, error, sweep_done, ch_sel, readings, target} !== 50'h0) begin bad++;
      $display("FAIL async_reset got=%0h/%b%b%b%b%b/%0d/%h/%h want=all0", state, db_req, sens_req,
               running, error, sweep_done, ch_sel, readings, target); end
    db_data = 8'h77; db_ack = 1'b1;
    @(negedge clock);
    rst = 1'b1;
    tick(1);
    db_ack = 1'b0;
    tick(1);
    total++; if (state !== 3'd0 || target !== 8'h00 || db_req !== 1'b0) begin bad++;
      $display("FAIL post_reset_ack got=%0h/%h/%b want=0/00/0", state, target, db_req); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_press_latency();
    test_sweep();
    test_stop_with_sample();
    test_ignored_handshakes();
    test_timeout();
    test_reset_midscan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trainer_session_ctrl.md
Name: trainer_session_ctrl

Overview:
- Session controller for the cycle trainer.
- Debounces the start/stop button and fetches the rider profile from the database over a req/ack handshake.
- Round-robin scans NUM_CH sensor channels over a second req/ack handshake and publishes per-channel OUT_W-bit readings.
- Downstream temperature/LED and resistance-pulse logic consume the readings; the block is the parametrised successor of the single-channel trainer control.

Parameters:
- NUM_CH, 4, number of sensor channels scanned (2..16).
- ADC_W, 12, ADC sample width.
- OUT_W, 8, published reading width (OUT_W <= ADC_W).
- TIMEOUT, 1000, max cycles waiting for any ack/valid before ERROR.
- DEB_CYC, 16, cycles the synchronised button must be stable to register.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- button  in  1  raw start/stop button, asynchronous.
- db_ack  in  1  database response valid, one-cycle pulse.
- db_data  in  OUT_W  profile target level, valid with db_ack.
- adc_valid  in  1  sensor sample valid, one-cycle pulse.
- adc_data  in  ADC_W  sample for channel ch_sel.
- db_req  out  1  database request, level.
- sens_req  out  1  sensor request, level.
- ch_sel  out  clog2(NUM_CH)  channel being requested.
- readings  out  NUM_CH*OUT_W  channel k at bits [k*OUT_W +: OUT_W].
- target  out  OUT_W  captured profile level.
- sweep_done  out  1  one-cycle pulse after the last channel of a sweep is captured.
- running  out  1  high in DB_REQ and SCAN.
- error  out  1  high in ERROR.
- state  out  3  encoded FSM state.

Behaviour:
- Reset (rst=0, async): state=IDLE(0); every output 0, including readings and target; internal sync, debounce, edge and timeout registers cleared.
- Button path:
  - 2-FF synchroniser, then a debounce counter.
  - The stable level updates after DEB_CYC consecutive equal samples.
  - A rising edge of the stable level produces `press`, a one-cycle pulse.
  - Latency from a clean button rise to `press` is DEB_CYC+3 cycles.
- IDLE(0): outputs quiet. `press` moves to DB_REQ.
- DB_REQ(1):
  - db_req=1, timeout counter runs.
  - On db_ack: capture db_data into target, clear timeout, go to SCAN with ch_sel=0. db_req drops the same edge.
  - Timeout reaching TIMEOUT-1 without ack goes to ERROR.
  - `press` here goes to STOP; abort takes priority over timeout.
- SCAN(2):
  - sens_req=1, ch_sel = current channel.
  - On adc_valid: write adc_data[ADC_W-1 -: OUT_W] into slot ch_sel. The slot is visible the next cycle.
  - ch_sel increments and wraps NUM_CH-1 -> 0; the timeout counter is cleared on each sample.
  - On the wrap, sweep_done pulses for one cycle, coincident with the last slot update.
  - No adc_valid within TIMEOUT cycles goes to ERROR.
  - adc_valid and `press` in the same cycle: the sample is captured (and sweep_done if applicable), then STOP.
- STOP(3): requests low for exactly one cycle, then IDLE. readings and target hold their values.
- ERROR(4):
  - error=1, requests low, readings held.
  - `press` goes to IDLE and clears error. A further press is needed to start a new session.
- General rules:
  - db_ack outside DB_REQ and adc_valid outside SCAN are ignored.
  - A new session restarts at channel 0; old readings persist until overwritten.
  - The timeout counter is clog2(TIMEOUT+1) bits, saturating, and cleared on every state change.
- Reset mid-operation: immediate return to IDLE with all outputs 0. An in-flight ack after reset is ignored.

Optional Feature:
- Macro: TRAINER_SAMPLE_AVG_EN.
- When defined: each slot stores the two-sample average (prev + new) >> 1, computed at OUT_W+1 bits with no overflow. The first sample of a slot after reset is stored raw.
- When undefined: raw truncated sample is stored; no extra registers.

Test Plan:
- Reset then button held high 30 cycles -> db_req rises 19 cycles after button rise (DEB_CYC+3); state=1, running=1.
- Button glitch high for 10 cycles -> no `press`; state stays 0; db_req stays 0.
- DB_REQ, db_ack with db_data=0x5A; then adc_valid with adc_data 0x123, 0x456, 0x789, 0xFFF on ch 0..3 -> target=0x5A; readings=0xFF_78_45_12; sweep_done pulses once, with the ch3 write; ch_sel back to 0.
- DB_REQ with no db_ack for 1000 cycles -> state=4, error=1, db_req=0; next press -> state=0, error=0.
- SCAN with adc_valid and `press` in the same cycle on ch1 -> slot 1 updated, state 3 for one cycle, then 0; sens_req=0.
- With TRAINER_SAMPLE_AVG_EN, ch0 samples 0x100 then 0x300 -> slot 0 = 0x10 then 0x20; rst low mid-SCAN -> all outputs 0 asynchronously.
